// File: rtl/y_arb4_rr_pkg.sv
// Shared types and helpers for the 4-way round-robin word arbiter.
package y_arb4_rr_pkg;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First valid requester at or after ptr, wrapping modulo NREQ.
  function automatic pick_t rr_pick(input logic [NREQ-1:0] valid,
                                    input logic [IDX_W-1:0] ptr);
    pick_t            p;
    logic [IDX_W-1:0] cand;
    p = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IDX_W'(ptr + IDX_W'(k));
      if (valid[cand]) begin
        p.hit = 1'b1;
        p.idx = cand;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/yMux4.sv
// Plain 4:1 word multiplexer used on the shared datapath.
module yMux4 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    unique case (sel)
      2'd0:    y = in0;
      2'd1:    y = in1;
      2'd2:    y = in2;
      default: y = in3;
    endcase
  end

endmodule

// File: rtl/y_arb4_rr.sv
// Round-robin arbiter for four valid/ready word producers with packet lock
// and a single registered output stage.
module y_arb4_rr
  import y_arb4_rr_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_valid,
  input  logic [3:0]       in_last,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [1:0]       out_src,
  input  logic             out_ready,
  output logic             busy
);

  state_t           state_q, state_nxt;
  logic [IDX_W-1:0] ptr_q, ptr_nxt;
  logic [IDX_W-1:0] owner_q, owner_nxt;
  logic [IDX_W-1:0] sel;
  logic             load_en;
  logic             xfer;
  logic [WIDTH-1:0] mux_word;
  pick_t            pick;

  assign load_en = !out_valid | out_ready;
  assign pick    = rr_pick(in_valid, ptr_q);
  assign busy    = (state_q == ST_LOCK);

  yMux4 #(.WIDTH(WIDTH)) u_mux (
    .in0 (in_data0),
    .in1 (in_data1),
    .in2 (in_data2),
    .in3 (in_data3),
    .sel (sel),
    .y   (mux_word)
  );

  // Grant, handshake and next-state decode.
  always_comb begin
    state_nxt = state_q;
    ptr_nxt   = ptr_q;
    owner_nxt = owner_q;
    in_ready  = '0;
    sel       = pick.idx;
    xfer      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (load_en && pick.hit) begin
          in_ready[pick.idx] = 1'b1;
          xfer               = 1'b1;
          if (in_last[pick.idx]) begin
            ptr_nxt = IDX_W'(pick.idx + 2'd1);
          end else begin
            state_nxt = ST_LOCK;
            owner_nxt = pick.idx;
          end
        end
      end
      ST_LOCK: begin
        sel               = owner_q;
        in_ready[owner_q] = load_en;
        if (load_en && in_valid[owner_q]) begin
          xfer = 1'b1;
          if (in_last[owner_q]) begin
            state_nxt = ST_IDLE;
            ptr_nxt   = IDX_W'(owner_q + 2'd1);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_nxt;
      ptr_q   <= ptr_nxt;
      owner_q <= owner_nxt;
    end
  end

  // Output stage: loads on transfer, empties when free and nothing arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else if (load_en) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= mux_word;
        out_last <= in_last[sel];
        out_src  <= sel;
      end
    end
  end

endmodule

// File: doc/y_arb4_rr.md
Name: y_arb4_rr

Overview:
- Round-robin arbiter and sequencer for the shared 4:1 word datapath.
- Four requesters offer WIDTH-bit words over valid/ready handshakes. The block drives the select of a yMux4 instance and registers the winning word into a single output stage.
- Multi-beat packets (delimited by in_last) are never interleaved.
- Sits in front of any single-consumer resource (ALU operand bus, memory write port) shared by four producers.

Parameters:
WIDTH, 32, data word width of each requester and of the output

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  4  per-requester word valid
in_last  in  4  per-requester last-beat-of-packet flag, qualified by in_valid
in_data0  in  WIDTH  requester 0 word
in_data1  in  WIDTH  requester 1 word
in_data2  in  WIDTH  requester 2 word
in_data3  in  WIDTH  requester 3 word
in_ready  out  4  per-requester accept; at most one bit high; combinational
out_valid  out  1  output word valid (registered)
out_data  out  WIDTH  registered granted word
out_last  out  1  registered last flag of that word
out_src  out  2  registered index of the requester that supplied out_data
out_ready  in  1  downstream accept
busy  out  1  high while a packet owner is locked (state LOCK)

Behaviour:
- Reset (async, immediate), all registers cleared:
  - state=IDLE, ptr=0, owner=0
  - out_valid=0, out_data=0, out_last=0, out_src=0
- Derived signals:
  - load_en = !out_valid | out_ready. The output register may take a new word this cycle.
  - A beat transfers on requester r when in_valid[r] & in_ready[r].
- in_ready is combinational from state, owner, ptr, in_valid and out_ready. It never depends on in_data.
- State IDLE:
  - g = first r with in_valid[r]=1, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - If load_en and any in_valid: in_ready[g]=1 and the yMux4 select = g.
    - Next edge: out_data<=in_dataG, out_last<=in_last[g], out_src<=g, out_valid<=1.
    - If in_last[g]=1: stay IDLE, ptr<=g+1 mod 4.
    - Else: state<=LOCK, owner<=g.
  - Otherwise: in_ready=0.
- State LOCK:
  - in_ready[owner] = load_en; all other in_ready=0; select = owner. Other requests are ignored even if valid.
  - On a transfer, the output register loads as in IDLE. If in_last[owner]=1, state<=IDLE and ptr<=owner+1 mod 4.
  - Owner in_valid low: hold LOCK with no timeout and no preemption. Output drains normally.
- Output register:
  - If load_en and no transfer occurs this cycle, out_valid<=0 on the next edge.
  - If out_valid & !out_ready, out_data/out_last/out_src hold stable and all in_ready=0.
- Throughput and latency:
  - Throughput is one word per cycle when out_ready stays high.
  - Latency is 1 cycle, from transfer edge to out_valid.
- ptr:
  - Advances only on completion of a packet (last beat accepted).
  - Wraps 3 -> 0.
  - A single-beat request with in_last=1 counts as a packet.
- Reset mid-packet: LOCK is abandoned and the partial packet is dropped from the output. The requester must restart its packet.
- busy = (state==LOCK).

Decomposition:
- Shared package holds:
  - state encoding constants: ST_IDLE=1'b0, ST_LOCK=1'b1
  - NREQ=4 and the requester index width of 2
- Datapath word selection instantiates the existing yMux4 #(WIDTH), driven by the 2-bit grant select. No other sub-module.
- The rotating priority search is a combinational function inside the block.

Test Plan:
- Reset: assert rst mid-cycle while out_valid=1 -> out_valid=0, out_data=0, out_src=0, busy=0 immediately; first grant after release is requester 0 when all four valid.
- Round robin: all four in_valid=1, in_last=4'b1111, out_ready=1 held, in_dataN=N+100 -> out_src sequence 0,1,2,3,0 on consecutive cycles; out_data 100,101,102,103,100; exactly one in_ready bit high each cycle.
- Packet lock:
  - Stimulus: requester 2 sends a 3-beat packet (0xA,0xB,0xC with last on 0xC) while requester 0 stays valid.
  - Response: out_src=2 for three consecutive words, busy=1 for the first two cycles, then requester 3 (if valid) else 0 is granted; ptr ends at 3.
- Back-pressure: out_ready=0 for 5 cycles with out_valid=1, out_data=0x55 -> out_data holds 0x55, in_ready=4'b0000 throughout; on out_ready=1 the next word loads in the same cycle.
- Owner stall: in LOCK with owner=1, drop in_valid[1] for 3 cycles while requesters 0,2,3 valid -> in_ready stays 4'b0000 except in_ready[1]; out_valid falls after drain; owner resumes and finishes its packet.
- Wrap/idle: only requester 3 valid single-beat, then only requester 0 -> grants 3 then 0, ptr 0 -> 0 (3+1 wraps to 0) then 1; with no in_valid, out_valid drops to 0 one cycle after the last accept.
